// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port byte memory between a CPU port (m0)
// and a DMA/loader port (m1). A port keeps the bus for at most MAX_BURST
// acked transfers while the other port waits. Handover between owners
// takes no idle cycle. Ties out of IDLE go to the port that did not own
// the bus most recently.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | nobody owns the bus; memory strobes, acks and rdata all 0
//   OWN0  | port 0 drives the memory; m0_ack follows m0_req
//   OWN1  | port 1 drives the memory; m1_ack follows m1_req
module mem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    output logic [7:0]  m0_rdata,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    output logic [7:0]  m1_rdata,
    output logic        m1_ack,

    output logic [15:0] mem_address,
    output logic        mem_write_en,
    output logic [7:0]  mem_data_out,
    input  logic [7:0]  mem_data_in,

    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    // Count value seen during the last ack a port may take while contended.
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] burst_cnt;
    logic [3:0] burst_cnt_next;
    logic       last_owner;       // 0 = port 0 owned last, 1 = port 1
    logic       last_owner_next;
    logic       ack_any;

    assign owner   = state;
    assign ack_any = m0_ack | m1_ack;

    // Next-state arbitration: tie-break on last owner, burst limit, release.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_next = last_owner ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_next = OWN0;
                end else if (m1_req) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                // The count can run past the limit while port 1 was silent;
                // once port 1 asks, the current ack is then the last one.
                if (!m0_req) begin
                    state_next = m1_req ? OWN1 : IDLE;
                end else if (m1_req && (burst_cnt >= BURST_LAST)) begin
                    state_next = OWN1;
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    state_next = m0_req ? OWN0 : IDLE;
                end else if (m0_req && (burst_cnt >= BURST_LAST)) begin
                    state_next = OWN0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Burst counter and last-owner bookkeeping for the coming edge.
    always_comb begin
        burst_cnt_next  = burst_cnt;
        last_owner_next = last_owner;
        if (state_next != state) begin
            burst_cnt_next = 4'd0;
        end else if (ack_any && (burst_cnt != 4'hF)) begin
            burst_cnt_next = burst_cnt + 4'd1;
        end
        if (state_next == OWN0) begin
            last_owner_next = 1'b0;
        end else if (state_next == OWN1) begin
            last_owner_next = 1'b1;
        end
    end

    // State registers; reset forces IDLE at once so strobes and acks drop
    // without waiting for a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            burst_cnt  <= 4'd0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_next;
            burst_cnt  <= burst_cnt_next;
            last_owner <= last_owner_next;
        end
    end

    // Memory and port outputs: only the owner's signals reach the memory.
    always_comb begin
        mem_address  = 16'h0000;
        mem_data_out = 8'h00;
        mem_write_en = 1'b0;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;
        m0_rdata     = 8'h00;
        m1_rdata     = 8'h00;
        case (state)
            OWN0: begin
                mem_address  = m0_addr;
                mem_data_out = m0_wdata;
                mem_write_en = m0_we & m0_req;
                m0_ack       = m0_req;
                if (m0_req && !m0_we) begin
                    m0_rdata = mem_data_in;
                end
            end
            OWN1: begin
                mem_address  = m1_addr;
                mem_data_out = m1_wdata;
                mem_write_en = m1_we & m1_req;
                m1_ack       = m1_req;
                if (m1_req && !m1_we) begin
                    m1_rdata = mem_data_in;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte memory model, per-port transfer drivers that
// push expected results into per-port queues, and a monitor that pops and
// compares them whenever a port is acked.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_we, m0_ack;
    logic [15:0] m0_addr;
    logic [7:0]  m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [15:0] m1_addr;
    logic [7:0]  m1_wdata, m1_rdata;
    logic [15:0] mem_address;
    logic        mem_write_en;
    logic [7:0]  mem_data_out, mem_data_in;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } sb_t;

    sb_t        q0[$];
    sb_t        q1[$];
    sb_t        mon_e;
    logic [1:0] hist[$];
    bit         mon_on = 1'b0;

    logic [7:0] mem [0:65535];

    mem_arbiter #(.MAX_BURST(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_rdata     (m0_rdata),
        .m0_ack       (m0_ack),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_rdata     (m1_rdata),
        .m1_ack       (m1_ack),
        .mem_address  (mem_address),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .owner        (owner)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single-port memory: combinational read, write on rising edge.
    assign mem_data_in = mem[mem_address];
    always @(posedge clock) begin
        if (mem_write_en === 1'b1) mem[mem_address] = mem_data_out;
    end

    // Scoreboard consumer: every ack must match the oldest queued transfer.
    always @(negedge clock) begin
        #2;
        if (reset === 1'b0) begin
            if (mon_on) hist.push_back({m1_ack, m0_ack});
            if (m0_ack === 1'b1) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL sb_port0: unexpected ack, addr=%h", mem_address);
                end else begin
                    mon_e = q0.pop_front();
                    if (mem_address !== mon_e.addr || mem_write_en !== mon_e.we ||
                        m1_ack !== 1'b0 || m1_rdata !== 8'h00 ||
                        (mon_e.we ? (mem_data_out !== mon_e.data || m0_rdata !== 8'h00)
                                  : (m0_rdata !== mon_e.data))) begin
                        bad++;
                        $display("FAIL sb_port0: got addr=%h we=%b wdata=%h rdata=%h m1_ack=%b, want addr=%h we=%b data=%h",
                                 mem_address, mem_write_en, mem_data_out, m0_rdata, m1_ack,
                                 mon_e.addr, mon_e.we, mon_e.data);
                    end
                end
            end
            if (m1_ack === 1'b1) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL sb_port1: unexpected ack, addr=%h", mem_address);
                end else begin
                    mon_e = q1.pop_front();
                    if (mem_address !== mon_e.addr || mem_write_en !== mon_e.we ||
                        m0_ack !== 1'b0 || m0_rdata !== 8'h00 ||
                        (mon_e.we ? (mem_data_out !== mon_e.data || m1_rdata !== 8'h00)
                                  : (m1_rdata !== mon_e.data))) begin
                        bad++;
                        $display("FAIL sb_port1: got addr=%h we=%b wdata=%h rdata=%h m0_ack=%b, want addr=%h we=%b data=%h",
                                 mem_address, mem_write_en, mem_data_out, m1_rdata, m0_ack,
                                 mon_e.addr, mon_e.we, mon_e.data);
                    end
                end
            end
        end
    end

    // One transfer on port p, called at a falling edge; returns at the
    // falling edge after the acked rising edge. Request dropped if last.
    task automatic xfer(input int p, input logic we, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] rd, input bit last);
        sb_t e;
        bit  got;
        e.we   = we;
        e.addr = a;
        e.data = we ? wd : rd;
        got    = 1'b0;
        if (p == 0) begin
            q0.push_back(e);
            m0_we = we; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
        end else begin
            q1.push_back(e);
            m1_we = we; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
        end
        for (int c = 0; c < 64 && !got; c++) begin
            #1;
            if ((p == 0) ? (m0_ack === 1'b1) : (m1_ack === 1'b1)) got = 1'b1;
            @(negedge clock);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL xfer_timeout: port=%0d addr=%h got no ack, want ack within 64 cycles", p, a);
        end
        if (last || !got) begin
            if (p == 0) m0_req = 1'b0;
            else        m1_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 16'h0000; m0_wdata = 8'h00;
        m1_req = 0; m1_we = 0; m1_addr = 16'h0000; m1_wdata = 8'h00;
        repeat (2) @(negedge clock);
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m0_addr = 16'hBEEF; m0_wdata = 8'h55;
        #1;
        total++;
        if (owner !== 2'b00 || m0_ack !== 1'b0 || m1_ack !== 1'b0 || mem_write_en !== 1'b0 ||
            mem_address !== 16'h0000 || mem_data_out !== 8'h00 ||
            m0_rdata !== 8'h00 || m1_rdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got owner=%b acks=%b%b we=%b addr=%h dout=%h rdata=%h/%h, want all 0",
                     owner, m1_ack, m0_ack, mem_write_en, mem_address, mem_data_out, m0_rdata, m1_rdata);
        end
        @(negedge clock); #1;
        total++;
        if (owner !== 2'b00) begin
            bad++;
            $display("FAIL reset_hold: got owner=%b, want 00", owner);
        end
        m0_req = 0; m1_req = 0; m0_we = 0; m0_addr = 16'h0000; m0_wdata = 8'h00;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock); #1;
        total++;
        if (owner !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle: got owner=%b, want 00", owner);
        end
    endtask

    task automatic test_tie();
        sb_t e;
        @(negedge clock);
        m0_we = 0; m0_addr = 16'h1234; m1_we = 0; m1_addr = 16'h0040;
        e.we = 0; e.addr = 16'h1234; e.data = 8'hA5; q0.push_back(e);
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        total++;
        if (owner !== 2'b00 || m0_ack !== 1'b0) begin
            bad++;
            $display("FAIL tie_latency: got owner=%b m0_ack=%b, want 00/0", owner, m0_ack);
        end
        @(negedge clock); #1;
        total++;
        if (owner !== 2'b01 || m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            bad++;
            $display("FAIL tie_first: got owner=%b m0_ack=%b m1_ack=%b, want 01/1/0", owner, m0_ack, m1_ack);
        end
        m1_req = 1'b0;
        @(negedge clock);
        m0_req = 1'b0;
        @(negedge clock); #1;
        total++;
        if (owner !== 2'b00) begin
            bad++;
            $display("FAIL tie_idle: got owner=%b, want 00", owner);
        end
        e.we = 0; e.addr = 16'h1234; e.data = 8'hA5; q0.push_back(e);
        e.we = 0; e.addr = 16'h0040; e.data = 8'h3C; q1.push_back(e);
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge clock); #1;
        total++;
        if (owner !== 2'b10 || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
            bad++;
            $display("FAIL tie_second: got owner=%b m1_ack=%b m0_ack=%b, want 10/1/0", owner, m1_ack, m0_ack);
        end
        @(negedge clock);
        m1_req = 1'b0;
        @(negedge clock); #1;
        total++;
        if (owner !== 2'b01 || m0_ack !== 1'b1) begin
            bad++;
            $display("FAIL tie_handover: got owner=%b m0_ack=%b, want 01/1", owner, m0_ack);
        end
        @(negedge clock);
        m0_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_read();
        @(negedge clock);
        fork
            xfer(0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b1);
            begin
                #1;
                total++;
                if (owner !== 2'b00 || m0_ack !== 1'b0) begin
                    bad++;
                    $display("FAIL read_latency: got owner=%b m0_ack=%b, want 00/0", owner, m0_ack);
                end
                @(negedge clock); #1;
                total++;
                if (owner !== 2'b01 || m0_ack !== 1'b1 || m0_rdata !== 8'hA5) begin
                    bad++;
                    $display("FAIL single_read: got owner=%b ack=%b rdata=%h, want 01/1/a5", owner, m0_ack, m0_rdata);
                end
            end
        join
    endtask

    task automatic test_release();
        #1;
        total++;
        if (owner !== 2'b01 || m0_ack !== 1'b0) begin
            bad++;
            $display("FAIL release_hold: got owner=%b m0_ack=%b, want 01/0", owner, m0_ack);
        end
        @(negedge clock); #1;
        total++;
        if (owner !== 2'b00) begin
            bad++;
            $display("FAIL release_idle: got owner=%b, want 00", owner);
        end
        @(negedge clock);
        fork
            xfer(1, 1'b0, 16'h0040, 8'h00, 8'h3C, 1'b1);
            begin
                @(negedge clock); #1;
                total++;
                if (owner !== 2'b10 || m1_ack !== 1'b1) begin
                    bad++;
                    $display("FAIL release_own1: got owner=%b m1_ack=%b, want 10/1", owner, m1_ack);
                end
            end
        join
        @(negedge clock); #1;
        total++;
        if (owner !== 2'b00) begin
            bad++;
            $display("FAIL release_idle2: got owner=%b, want 00", owner);
        end
    endtask

    task automatic test_burst();
        logic [1:0] seq[$];
        logic [1:0] exp_code;
        int first;
        int last_i;
        first  = -1;
        last_i = -1;
        hist.delete();
        mon_on = 1'b1;
        @(negedge clock);
        fork
            for (int i = 0; i < 4; i++)
                xfer(0, 1'b1, 16'h0200 + 16'(i), 8'h10 + 8'(i), 8'h00, i == 3);
            for (int j = 0; j < 4; j++)
                xfer(1, 1'b1, 16'h0300 + 16'(j), 8'h20 + 8'(j), 8'h00, j == 3);
        join
        repeat (3) @(negedge clock);
        #3;
        mon_on = 1'b0;
        foreach (hist[k]) begin
            if (hist[k] != 2'b00) begin
                if (first < 0) first = k;
                last_i = k;
                seq.push_back(hist[k]);
            end
        end
        total++;
        if (seq.size() != 8) begin
            bad++;
            $display("FAIL burst_count: got %0d acked cycles, want 8", seq.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                exp_code = (k < 4) ? 2'b01 : 2'b10;
                total++;
                if (seq[k] !== exp_code) begin
                    bad++;
                    $display("FAIL burst_order[%0d]: got acks=%b, want %b", k, seq[k], exp_code);
                end
            end
        end
        total++;
        if (last_i - first + 1 != 8) begin
            bad++;
            $display("FAIL burst_gap: got span=%0d cycles, want 8", last_i - first + 1);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[16'h0200 + 16'(i)] !== 8'h10 + 8'(i) || mem[16'h0300 + 16'(i)] !== 8'h20 + 8'(i)) begin
                bad++;
                $display("FAIL burst_mem[%0d]: got %h/%h, want %h/%h", i,
                         mem[16'h0200 + 16'(i)], mem[16'h0300 + 16'(i)], 8'h10 + 8'(i), 8'h20 + 8'(i));
            end
        end
    endtask

    task automatic test_isolation();
        @(negedge clock);
        fork
            for (int i = 0; i < 8; i++)
                xfer(0, 1'b0, 16'h0000, 8'h00, 8'h5A, i == 7);
            for (int k = 0; k < 10; k++) begin
                @(negedge clock); #3;
                m1_addr  = k[0] ? 16'h0001 : 16'hFFFF;
                m1_wdata = 8'(k);
                m1_we    = k[0];
                #1;
                total++;
                if (mem_address !== 16'h0000 || m1_ack !== 1'b0 || mem_write_en !== 1'b0) begin
                    bad++;
                    $display("FAIL isolation[%0d]: got addr=%h m1_ack=%b we=%b, want 0000/0/0",
                             k, mem_address, m1_ack, mem_write_en);
                end
            end
        join
        m1_we = 1'b0; m1_addr = 16'h0000; m1_wdata = 8'h00;
    endtask

    task automatic test_reset_mid_write();
        sb_t e;
        @(negedge clock);
        m1_we = 1'b1; m1_addr = 16'hF010; m1_wdata = 8'hEE; m1_req = 1'b1;
        @(negedge clock); #1;
        total++;
        if (owner !== 2'b10 || mem_write_en !== 1'b1) begin
            bad++;
            $display("FAIL rmw_setup: got owner=%b we=%b, want 10/1", owner, mem_write_en);
        end
        reset = 1'b1;
        #1;
        total++;
        if (mem_write_en !== 1'b0 || owner !== 2'b00 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            bad++;
            $display("FAIL rmw_async: got we=%b owner=%b acks=%b%b, want 0/00/00",
                     mem_write_en, owner, m1_ack, m0_ack);
        end
        @(negedge clock);
        total++;
        if (mem[16'hF010] !== 8'h77) begin
            bad++;
            $display("FAIL rmw_mem: got mem[f010]=%h, want 77", mem[16'hF010]);
        end
        m1_req = 1'b0; m1_we = 1'b0;
        m0_we = 1'b0; m0_addr = 16'h1234; m0_req = 1'b1;
        @(negedge clock); #1;
        total++;
        if (owner !== 2'b00) begin
            bad++;
            $display("FAIL rmw_in_reset: got owner=%b, want 00", owner);
        end
        e.we = 0; e.addr = 16'h1234; e.data = 8'hA5; q0.push_back(e);
        reset = 1'b0;
        #1;
        total++;
        if (owner !== 2'b00) begin
            bad++;
            $display("FAIL first_arb_wait: got owner=%b, want 00", owner);
        end
        @(negedge clock); #1;
        total++;
        if (owner !== 2'b01 || m0_ack !== 1'b1) begin
            bad++;
            $display("FAIL first_arb: got owner=%b m0_ack=%b, want 01/1", owner, m0_ack);
        end
        @(negedge clock);
        m0_req = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'hA5;
        mem[16'h0040] = 8'h3C;
        mem[16'h0000] = 8'h5A;
        mem[16'hF010] = 8'h77;
        test_reset();
        test_tie();
        test_single_read();
        test_release();
        test_burst();
        test_isolation();
        test_reset_mid_write();
        #3;
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d/%0d pending transfers, want 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, want bench to finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive acked transfers a port keeps the bus while the other port is requesting; legal range 1..15.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0_req  input  1  port 0 (CPU) transfer request, held until acked.
REQ-005 m0_we  input  1  port 0 write enable: 1 = write, 0 = read.
REQ-006 m0_addr  input  16  port 0 byte address.
REQ-007 m0_wdata  input  8  port 0 write data.
REQ-008 m0_rdata  output  8  port 0 read data, valid in the m0_ack cycle.
REQ-009 m0_ack  output  1  port 0 transfer completes at the next rising edge.
REQ-010 m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same widths and meanings as REQ-004..009, for port 1 (DMA/loader).
REQ-011 mem_address  output  16  address to the single-port memory.
REQ-012 mem_write_en  output  1  memory write strobe; memory writes on rising edge.
REQ-013 mem_data_out  output  8  write data to memory.
REQ-014 mem_data_in  input  8  combinational read data from memory.
REQ-015 owner  output  2  00 = idle, 01 = port 0, 10 = port 1.

Function
REQ-016 The arbiter SHALL implement states IDLE, OWN0 and OWN1, held in registers; owner SHALL reflect the state directly.
REQ-017 In IDLE, all mem_* outputs, both acks and both rdata outputs SHALL be 0.
REQ-018 In IDLE with exactly one req high, the next state SHALL be that port's OWN state, giving 1 cycle of arbitration latency; IDLE never acks.
REQ-019 In IDLE with both reqs high, the port not equal to last_owner SHALL win; last_owner updates on every entry to OWN0/OWN1.
REQ-020 In OWNx, mem_address, mem_data_out and mem_write_en SHALL combinationally follow mx_addr, mx_wdata and (mx_we AND mx_req).
REQ-021 In OWNx, mx_ack SHALL equal mx_req combinationally, and the other port's ack SHALL be 0.
REQ-022 In OWNx, mx_rdata SHALL equal mem_data_in when mx_ack=1 and mx_we=0; otherwise it SHALL be 0. The non-owner rdata SHALL be 0.
REQ-023 A 4-bit burst counter SHALL clear on entry to any OWN state and increment on each acked cycle; it saturates at 15.
REQ-024 In OWNx with mx_req=0: if the other req=1, the next state SHALL be OWN(other) directly; otherwise it SHALL be IDLE.
REQ-025 In OWNx with an ack, the other req=1 and counter = MAX_BURST-1, the next state SHALL be OWN(other), so the current ack is the last one.
REQ-026 In OWNx with an ack and the other req=0, the owner SHALL keep the bus indefinitely; the counter still counts.
REQ-027 Owner-to-owner handover SHALL insert no idle cycle.
REQ-028 When MAX_BURST=1 and both ports request continuously, grants SHALL alternate each cycle.
REQ-029 Changes on a non-owner's request inputs SHALL never affect the mem_* outputs.

Reset
REQ-030 While reset=1, the state SHALL be IDLE, the counter 0 and last_owner port 1, so port 0 wins the first tie.
REQ-031 Reset asserted mid-transfer SHALL force mem_write_en=0 and both acks=0 immediately, without waiting for a clock edge.
REQ-032 The first arbitration after reset release SHALL occur on the first rising edge with reset=0.

Verification
REQ-033 Single read: memory[0x1234]=0xA5, m0_req=1, m0_we=0, addr=0x1234 -> owner=01 after 1 edge; m0_ack=1 and m0_rdata=0xA5 in that cycle.
REQ-034 Tie: both reqs rise together after reset -> port 0 owns first; at the next IDLE tie, port 1 wins.
REQ-035 Burst limit: MAX_BURST=4, both reqs held; m0 writes 0x10..0x13 to 0x0200..0x0203 -> exactly 4 m0_acks, then owner=10 with no gap, then 4 m1_acks; memory contents verified.
REQ-036 Release: m0 owns, m0_req drops while m1_req=0 -> IDLE; m1_req then rises -> OWN1 one edge later.
REQ-037 Reset mid-write: OWN1 with m1_we=1 at 0xF010; assert reset between edges -> mem_write_en=0 immediately, owner=00, memory[0xF010] unchanged.
REQ-038 Non-owner isolation: m0 reads 0x0000 continuously while m1_addr toggles between 0xFFFF and 0x0001 with m1_req=0 -> mem_address stays 0x0000 and m1_ack stays 0.
